fifo_consumer: RTL and testbench
================================

Name: fifo_consumer

Overview:
Consumer-side stage on the async FIFO read port, in the CON_CLK domain.
- Drains the FIFO in bursts of P_BURST_LEN reads separated by P_IDLE_CYCLES idle cycles, so the FIFO sees a slow, bursty reader.
- Checks each word read against an expected incrementing sequence.
- Reports the stream, read count, error count and a sticky error flag to the testbench scoreboard.

Parameters:
P_DATA_WIDTH, 8, width of FIFO data.
P_BURST_LEN, 4, reads per burst (>=1).
P_IDLE_CYCLES, 2, idle cycles between bursts (0 = continuous reading).
P_SEED, 0, first expected data value after reset or clear.

Ports:
CON_CLK  input  1  consumer clock; all state on rising edge.
RST_n  input  1  asynchronous active-low reset.
I_ENABLE  input  1  allow reading; sampled every cycle.
I_CLR  input  1  synchronous clear of counters, error flag and expected value.
I_DATA  input  P_DATA_WIDTH  FIFO read data, valid the cycle after O_RD_EN.
I_EMPTY  input  1  FIFO empty flag.
O_RD_EN  output  1  FIFO read request.
O_DATA  output  P_DATA_WIDTH  last captured word.
O_DATA_VLD  output  1  one-cycle pulse; O_DATA is new.
O_RD_CNT  output  16  words captured, saturating.
O_ERR_CNT  output  16  mismatches, saturating.
O_ERR  output  1  sticky: set on first mismatch.

Behaviour:
- Clock and reset: one clock, CON_CLK. RST_n is asynchronous and active-low.
- Reset values: state=IDLE, O_RD_EN=0, O_DATA=0, O_DATA_VLD=0, O_RD_CNT=0, O_ERR_CNT=0, O_ERR=0, expected=P_SEED, burst_cnt=0, idle_cnt=0, rd_pend=0.
- Read enable: O_RD_EN = (state==READ) && !I_EMPTY. Combinational, so a read is never issued on empty.
- States:
  - IDLE: if I_ENABLE, go to READ; otherwise stay.
  - READ: each cycle with O_RD_EN=1, burst_cnt++.
    - On the read that makes burst_cnt==P_BURST_LEN: clear burst_cnt. Go to PAUSE with idle_cnt=P_IDLE_CYCLES, or stay in READ if P_IDLE_CYCLES==0.
    - If I_ENABLE=0: go to IDLE (a read issued that same cycle still completes). burst_cnt is kept.
  - PAUSE: idle_cnt-- each cycle.
    - When idle_cnt reaches 1: go to READ if I_ENABLE, else IDLE.
    - I_ENABLE=0 during PAUSE: go to IDLE immediately.
- Empty during a burst: no read that cycle, burst_cnt holds, state stays READ. Empty cycles do not count as idle cycles.
- Capture pipeline: rd_pend <= O_RD_EN. In the cycle after a read (rd_pend=1), I_DATA is valid. On that clock edge:
  - O_DATA <= I_DATA; O_DATA_VLD <= 1 (pulse, 0 otherwise).
  - O_RD_CNT++ (saturates at 0xFFFF).
  - If I_DATA != expected: O_ERR_CNT++ (saturating), O_ERR <= 1.
  - expected <= I_DATA + 1 mod 2^P_DATA_WIDTH, always (resync, so one dropped or duplicated word costs one error).
- Latency: read request in cycle N, data sampled at end of N+1, O_DATA_VLD high in N+2. Back-to-back reads give one O_DATA_VLD per cycle.
- Wrap: expected wraps 0xFF->0x00 with no error.
- I_CLR=1: O_RD_CNT=0, O_ERR_CNT=0, O_ERR=0, expected=P_SEED. FSM, burst_cnt and rd_pend are not affected.
  - A capture in the same cycle is compared against the pre-clear expected value but is not counted. Clear has priority for all counters and the flag.
- Reset mid-operation: all registers return to reset values at once; any pending read's data is discarded. The FIFO side owns its own reset.

Decomposition:
- Package ccd_pkg:
  - typedef enum logic [1:0] cons_state_t {IDLE, READ, PAUSE}.
  - localparam CNT_W=16.
  - Shared with the future producer block.
- One sub-module, seq_checker (data width param, seed param): owns expected, the compare, O_ERR_CNT and O_ERR.
- fifo_consumer holds the FSM, burst/idle counters, rd_pend, O_DATA/O_DATA_VLD and O_RD_CNT.

Test Plan:
- Reset with I_ENABLE=1, FIFO preloaded 0..7, defaults:
  - reads occur in cycles 1-4, none in 5-6, then 7-10.
  - O_DATA_VLD stream is 0..7; O_RD_CNT=8; O_ERR=0.
- FIFO goes empty after word 2 mid-burst for 3 cycles:
  - O_RD_EN=0 while empty; burst resumes and ends after 4 total reads.
  - No extra PAUSE cycles are inserted.
- FIFO data 0,1,2,4,5:
  - O_ERR_CNT=1 and O_ERR=1, set at the capture of 4.
  - 5 checks OK; O_RD_CNT=5.
- 300 sequential words with P_IDLE_CYCLES=0:
  - 0xFF->0x00 wrap gives no error; O_RD_CNT=300.
  - O_RD_EN is continuously high while not empty.
- RST_n low asynchronously one cycle after a read:
  - all outputs 0 immediately; no O_DATA_VLD for the pending read.
  - After release, the first expected value is P_SEED.
- I_CLR pulse after 3 errors:
  - O_ERR_CNT=0, O_ERR=0.
  - Next data P_SEED checks clean.
- I_ENABLE dropped in PAUSE:
  - IDLE next cycle; no reads until I_ENABLE returns.

Source files
------------

// File: rtl/ccd_pkg.sv
// Types and helpers shared by the consumer/producer pair on either side of
// the async FIFO.
package ccd_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    PAUSE
  } cons_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/seq_checker.sv
// Compares captured words against an incrementing sequence and keeps the
// error count and the sticky error flag.
module seq_checker
  import ccd_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_SEED       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    chk,
  input  logic [P_DATA_WIDTH-1:0] data,
  output logic [CNT_W-1:0]        err_cnt,
  output logic                    err
);

  localparam logic [P_DATA_WIDTH-1:0] SEED = P_DATA_WIDTH'(P_SEED);

  logic [P_DATA_WIDTH-1:0] expected;
  logic                    mismatch;

  assign mismatch = chk && (data != expected);

  // Expected always resyncs to the captured word, so a single dropped or
  // duplicated word costs exactly one error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected <= SEED;
      err_cnt  <= '0;
      err      <= 1'b0;
    end else if (clr) begin
      expected <= SEED;
      err_cnt  <= '0;
      err      <= 1'b0;
    end else if (chk) begin
      expected <= data + P_DATA_WIDTH'(1);
      if (mismatch) begin
        err_cnt <= sat_inc(err_cnt);
        err     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_consumer.sv
// Bursty reader on the async FIFO read port: P_BURST_LEN reads, then
// P_IDLE_CYCLES idle cycles, with captured words checked in sequence.
module fifo_consumer
  import ccd_pkg::*;
#(
  parameter int P_DATA_WIDTH  = 8,
  parameter int P_BURST_LEN   = 4,
  parameter int P_IDLE_CYCLES = 2,
  parameter int P_SEED        = 0
) (
  input  logic                    CON_CLK,
  input  logic                    RST_n,
  input  logic                    I_ENABLE,
  input  logic                    I_CLR,
  input  logic [P_DATA_WIDTH-1:0] I_DATA,
  input  logic                    I_EMPTY,
  output logic                    O_RD_EN,
  output logic [P_DATA_WIDTH-1:0] O_DATA,
  output logic                    O_DATA_VLD,
  output logic [CNT_W-1:0]        O_RD_CNT,
  output logic [CNT_W-1:0]        O_ERR_CNT,
  output logic                    O_ERR
);

  localparam int BW = (P_BURST_LEN < 2) ? 1 : $clog2(P_BURST_LEN);
  localparam int IW = (P_IDLE_CYCLES < 2) ? 1 : $clog2(P_IDLE_CYCLES + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(P_BURST_LEN - 1);
  localparam logic [IW-1:0] IDLE_LOAD  = IW'(P_IDLE_CYCLES);
  localparam logic [IW-1:0] IDLE_ONE   = IW'(1);

  cons_state_t   state, state_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic          rd_pend;

  assign O_RD_EN = (state == READ) && !I_EMPTY;

  always_ff @(posedge CON_CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      idle_cnt  <= idle_nxt;
    end
  end

  // A read issued in the same cycle enable drops still counts toward the burst.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    idle_nxt  = idle_cnt;
    case (state)
      IDLE: begin
        if (I_ENABLE) state_nxt = READ;
      end
      READ: begin
        if (O_RD_EN) begin
          if (burst_cnt == BURST_LAST) begin
            burst_nxt = '0;
            if (P_IDLE_CYCLES != 0) begin
              state_nxt = PAUSE;
              idle_nxt  = IDLE_LOAD;
            end
          end else begin
            burst_nxt = burst_cnt + BW'(1);
          end
        end
        if (!I_ENABLE) state_nxt = IDLE;
      end
      PAUSE: begin
        idle_nxt = idle_cnt - IW'(1);
        if (!I_ENABLE)                state_nxt = IDLE;
        else if (idle_cnt == IDLE_ONE) state_nxt = READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CON_CLK or negedge RST_n) begin
    if (!RST_n) begin
      rd_pend    <= 1'b0;
      O_DATA     <= '0;
      O_DATA_VLD <= 1'b0;
      O_RD_CNT   <= '0;
    end else begin
      rd_pend    <= O_RD_EN;
      O_DATA_VLD <= rd_pend;
      if (rd_pend) O_DATA <= I_DATA;
      if (I_CLR)        O_RD_CNT <= '0;
      else if (rd_pend) O_RD_CNT <= sat_inc(O_RD_CNT);
    end
  end

  seq_checker #(
    .P_DATA_WIDTH(P_DATA_WIDTH),
    .P_SEED      (P_SEED)
  ) u_chk (
    .clk    (CON_CLK),
    .rst_n  (RST_n),
    .clr    (I_CLR),
    .chk    (rd_pend),
    .data   (I_DATA),
    .err_cnt(O_ERR_CNT),
    .err    (O_ERR)
  );

endmodule

// File: tb/tb_fifo_consumer.sv
// Two consumers (idle gap 2 and idle gap 0) against a bench FIFO, checked each
// cycle against a schedule/scoreboard model plus hand-computed expectations.
module tb_fifo_consumer;

  localparam int DW   = 8;
  localparam int BL   = 4;
  localparam int SEED = 0;
  localparam int FD   = 512;

  logic clk = 1'b0;
  logic rst_n, en, clr;

  logic          rd_en [2];
  logic [DW-1:0] dout  [2];
  logic          vld   [2];
  logic [15:0]   rcnt  [2];
  logic [15:0]   ecnt  [2];
  logic          err   [2];
  logic [DW-1:0] din   [2];
  logic          empty [2];

  logic [DW-1:0] fmem [2][FD];
  int            f_head [2];
  int            f_tail [2];
  logic          rd_seen [2];

  // model: awake = consumer enabled, gap = idle cycles still owed after a burst
  bit            m_awake [2];
  int            m_taken [2];
  int            m_gap   [2];
  bit            p_valid [2];
  logic [DW-1:0] p_word  [2];
  bit            m_vld   [2];
  logic [DW-1:0] m_data  [2];
  int            m_cnt   [2];
  int            m_ecnt  [2];
  bit            m_err   [2];
  logic [DW-1:0] m_exp   [2];

  logic [15:0] mask [2];
  int          kc;
  int          stall1;
  int          total = 0;
  int          bad   = 0;

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_consumer #(
      .P_DATA_WIDTH (DW),
      .P_BURST_LEN  (BL),
      .P_IDLE_CYCLES((g == 0) ? 2 : 0),
      .P_SEED       (SEED)
    ) dut (
      .CON_CLK   (clk),
      .RST_n     (rst_n),
      .I_ENABLE  (en),
      .I_CLR     (clr),
      .I_DATA    (din[g]),
      .I_EMPTY   (empty[g]),
      .O_RD_EN   (rd_en[g]),
      .O_DATA    (dout[g]),
      .O_DATA_VLD(vld[g]),
      .O_RD_CNT  (rcnt[g]),
      .O_ERR_CNT (ecnt[g]),
      .O_ERR     (err[g])
    );
    assign empty[g] = (f_head[g] == f_tail[g]);
  end

  task automatic check(input string name, input int g, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d at %0t", name, g, act, want, $time);
    end
  endtask

  task automatic push(input int g, input int v);
    fmem[g][f_tail[g] % FD] = v[DW-1:0];
    f_tail[g]++;
  endtask

  task automatic push_both(input int v);
    push(0, v);
    push(1, v);
  endtask

  task automatic mask_start();
    mask[0] = '0;
    mask[1] = '0;
    kc = 0;
  endtask

  task automatic model_cycle();
    for (int g = 0; g < 2; g++) begin
      bit rd;
      int gap_len;
      gap_len = (g == 0) ? 2 : 0;
      if (!rst_n) begin
        m_awake[g] = 0; m_taken[g] = 0; m_gap[g] = 0; p_valid[g] = 0;
        m_vld[g] = 0; m_data[g] = '0; m_cnt[g] = 0; m_ecnt[g] = 0;
        m_err[g] = 0; m_exp[g] = DW'(SEED);
      end
      rd = m_awake[g] && (m_gap[g] == 0) && (f_head[g] != f_tail[g]);
      check("rd_en", g, int'(rd_en[g]), int'(rd));
      check("data_vld", g, int'(vld[g]), int'(m_vld[g]));
      check("data", g, int'(dout[g]), int'(m_data[g]));
      check("rd_cnt", g, int'(rcnt[g]), m_cnt[g]);
      check("err_cnt", g, int'(ecnt[g]), m_ecnt[g]);
      check("err", g, int'(err[g]), int'(m_err[g]));
      rd_seen[g] = rd_en[g];
      if (g == 1 && f_head[1] != f_tail[1] && !rd_en[1]) stall1++;
      if (rst_n) begin
        m_vld[g] = p_valid[g];
        if (p_valid[g]) begin
          m_data[g] = p_word[g];
          if (m_cnt[g] < 65535) m_cnt[g]++;
          if (p_word[g] != m_exp[g]) begin
            if (m_ecnt[g] < 65535) m_ecnt[g]++;
            m_err[g] = 1;
          end
          m_exp[g] = p_word[g] + 8'd1;
        end
        if (clr) begin
          m_cnt[g] = 0; m_ecnt[g] = 0; m_err[g] = 0; m_exp[g] = DW'(SEED);
        end
        p_valid[g] = rd;
        p_word[g]  = fmem[g][f_head[g] % FD];
        if (!m_awake[g]) begin
          m_awake[g] = en;
        end else if (m_gap[g] > 0) begin
          m_gap[g]--;
          if (!en) begin m_awake[g] = 0; m_gap[g] = 0; end
        end else begin
          if (rd) begin
            m_taken[g]++;
            if (m_taken[g] == BL) begin m_taken[g] = 0; m_gap[g] = gap_len; end
          end
          if (!en) begin m_awake[g] = 0; m_gap[g] = 0; end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      if (rd_seen[g] && f_head[g] != f_tail[g]) begin
        din[g] = fmem[g][f_head[g] % FD];
        f_head[g]++;
      end
      if (rd_seen[g] && kc < 16) mask[g][kc] = 1'b1;
    end
    kc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int w;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0;
    din[0] = '0; din[1] = '0;
    rd_seen[0] = 1'b0; rd_seen[1] = 1'b0;
    stall1 = 0;
    mask_start();

    // preloaded 0..7: reads in cycles 1-4 and 7-10 for the gap-2 consumer
    for (int i = 0; i < 8; i++) push_both(i);
    ticks(2);
    check("reset_rd_cnt", 0, int'(rcnt[0]), 0);
    check("reset_err", 0, int'(err[0]), 0);
    rst_n = 1'b1;
    mask_start();
    ticks(14);
    check("s1_rdmask", 0, int'(mask[0]), 16'h079E);
    check("s1_rdmask", 1, int'(mask[1]), 16'h01FE);
    check("s1_rd_cnt", 0, int'(rcnt[0]), 8);
    check("s1_data", 0, int'(dout[0]), 7);
    check("s1_err", 0, int'(err[0]), 0);

    // empty after two words of a burst: burst resumes, no extra pause
    push_both(8); push_both(9);
    mask_start();
    ticks(5);
    for (int i = 10; i < 16; i++) push_both(i);
    ticks(12);
    check("s2_rdmask", 0, int'(mask[0]), 16'h1E63);
    check("s2_rd_cnt", 0, int'(rcnt[0]), 16);
    check("s2_rd_cnt", 1, int'(rcnt[1]), 16);

    // skipped word: one error raised at the capture of 4
    clr = 1'b1; tick(); clr = 1'b0;
    check("s3_clr_cnt", 0, int'(rcnt[0]), 0);
    push_both(0); push_both(1); push_both(2); push_both(4); push_both(5);
    ticks(20);
    check("s3_rd_cnt", 0, int'(rcnt[0]), 5);
    check("s3_err_cnt", 0, int'(ecnt[0]), 1);
    check("s3_err", 0, int'(err[0]), 1);
    check("s3_data", 1, int'(dout[1]), 5);

    // three more errors, then clear and restart from the seed
    push_both(9); push_both(3); push_both(7);
    ticks(15);
    check("s4_err_cnt", 0, int'(ecnt[0]), 4);
    clr = 1'b1; tick(); clr = 1'b0;
    check("s4_clr_err_cnt", 0, int'(ecnt[0]), 0);
    check("s4_clr_err", 1, int'(err[1]), 0);
    push_both(SEED);
    ticks(12);
    check("s4_seed_err", 0, int'(err[0]), 0);
    check("s4_seed_cnt", 0, int'(rcnt[0]), 1);

    // asynchronous reset the cycle after a read
    push_both(1); push_both(2); push_both(3);
    w = 0;
    while (!rd_seen[0] && w < 30) begin tick(); w++; end
    check("s5_read_seen", 0, int'(rd_seen[0]), 1);
    #3 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check("s5_async_vld", g, int'(vld[g]), 0);
      check("s5_async_cnt", g, int'(rcnt[g]), 0);
      check("s5_async_rd_en", g, int'(rd_en[g]), 0);
    end
    ticks(2);
    f_head[0] = f_tail[0]; f_head[1] = f_tail[1];
    rst_n = 1'b1;

    // enable dropped during the pause
    for (int i = 0; i < 8; i++) push_both(i);
    mask_start();
    ticks(5);
    en = 1'b0;
    ticks(6);
    en = 1'b1;
    ticks(5);
    check("s6_rdmask", 0, int'(mask[0]), 16'hF01E);
    check("s6_rdmask", 1, int'(mask[1]), 16'h703E);
    ticks(4);
    check("s6_rd_cnt", 0, int'(rcnt[0]), 8);
    check("s6_err", 0, int'(err[0]), 0);

    // 300 sequential words across the 0xFF->0x00 wrap
    clr = 1'b1; tick(); clr = 1'b0;
    stall1 = 0;
    for (int i = 0; i < 300; i++) push_both(i % 256);
    w = 0;
    while ((f_head[0] != f_tail[0] || f_head[1] != f_tail[1]) && w < 800) begin
      tick(); w++;
    end
    check("s7_drain_in_time", 0, int'(w < 800), 1);
    ticks(4);
    for (int g = 0; g < 2; g++) begin
      check("s7_rd_cnt", g, int'(rcnt[g]), 300);
      check("s7_err_cnt", g, int'(ecnt[g]), 0);
      check("s7_data", g, int'(dout[g]), 43);
    end
    check("s7_stall", 1, stall1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
